// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave front end.
//   i2c_mon_state_t : transaction sequencer states of i2c_bus_monitor
//   ADDR_BITS       : address bits per address frame
//   BYTE_BITS       : data bits per byte
//   ACK_SLOT        : bit_cnt value that marks the ninth (acknowledge) clock
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        ACK,
        DATA,
        IGNORE
    } i2c_mon_state_t;

    localparam int ADDR_BITS = 7;
    localparam int BYTE_BITS = 8;
    localparam int ACK_SLOT  = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one raw I2C line into the local clock domain.
//   clk, rst        : local clock, synchronous active-high reset
//   line_in         : raw asynchronous pin
//   line            : synchronised line (last synchroniser stage)
//   line_prev       : line delayed by one clock
//   rise, fall      : one-cycle edge strobes derived from line/line_prev
// SYNC_STAGES must be at least 2. Everything resets to 1 (released bus).
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line,
    output logic line_prev,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], line_in};
            line_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign line = sync_q[SYNC_STAGES-1];
    assign rise = line & ~line_prev;
    assign fall = ~line & line_prev;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Front end of the I2C slave: synchronises SCL/SDA, detects START/STOP,
// sequences the address / R/W / ACK / data slots and drives the address
// decoder.
//   FPGA_clk, rst              : system clock (>= 4x SCL), sync active-high reset
//   SCL_in, SDA_in             : raw bus pins
//   addr_done, addr_selected   : address decoder result
//   SCL, SDA, SCL_prev         : synchronised lines to the decoder
//   scl_rise, scl_fall         : SCL edge strobes
//   start_det, stop_det        : bus condition strobes
//   bus_busy                   : high between START and STOP
//   addr_enable, addr_rst      : decoder enable / restart
//   rw_bit, rw_valid           : sampled R/W bit and its update strobe
//   sda_oe                     : 1 pulls SDA low (address ACK)
//   bit_cnt                    : bit position in the current frame
//   byte_done                  : strobe after the 8th data bit
//   nack_ignored               : transaction addressed elsewhere
module i2c_bus_monitor
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       FPGA_clk,
    input  logic       rst,
    input  logic       SCL_in,
    input  logic       SDA_in,
    input  logic       addr_done,
    input  logic       addr_selected,
    output logic       SCL,
    output logic       SDA,
    output logic       SCL_prev,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       addr_enable,
    output logic       addr_rst,
    output logic       rw_bit,
    output logic       rw_valid,
    output logic       sda_oe,
    output logic [3:0] bit_cnt,
    output logic       byte_done,
    output logic       nack_ignored
);

    logic sda_prev, sda_rise, sda_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk      (FPGA_clk),
        .rst      (rst),
        .line_in  (SCL_in),
        .line     (SCL),
        .line_prev(SCL_prev),
        .rise     (scl_rise),
        .fall     (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk      (FPGA_clk),
        .rst      (rst),
        .line_in  (SDA_in),
        .line     (SDA),
        .line_prev(sda_prev),
        .rise     (sda_rise),
        .fall     (sda_fall)
    );

    // SCL must be high in both samples, so an SDA edge that lands in the
    // same sample as an SCL edge is never taken as a condition.
    assign start_det = SCL & SCL_prev & sda_fall;
    assign stop_det  = SCL & SCL_prev & sda_rise;

    i2c_mon_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic sda_oe_q, sda_oe_d;
    logic rw_bit_q, rw_bit_d;
    logic rw_valid_q, rw_valid_d;
    logic byte_done_q, byte_done_d;
    logic bus_busy_q, bus_busy_d;
    logic addr_rst_q, addr_rst_d;

    // State and datapath registers.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sda_oe_q    <= 1'b0;
            rw_bit_q    <= 1'b0;
            rw_valid_q  <= 1'b0;
            byte_done_q <= 1'b0;
            bus_busy_q  <= 1'b0;
            addr_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sda_oe_q    <= sda_oe_d;
            rw_bit_q    <= rw_bit_d;
            rw_valid_q  <= rw_valid_d;
            byte_done_q <= byte_done_d;
            bus_busy_q  <= bus_busy_d;
            addr_rst_q  <= addr_rst_d;
        end
    end

    // Next-state logic: STOP beats START beats per-state behaviour.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sda_oe_d    = sda_oe_q;
        rw_bit_d    = rw_bit_q;
        rw_valid_d  = 1'b0;
        byte_done_d = 1'b0;
        bus_busy_d  = bus_busy_q;
        addr_rst_d  = 1'b0;

        if (stop_det) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            bus_busy_d = 1'b0;
        end else if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = '0;
            sda_oe_d   = 1'b0;
            bus_busy_d = 1'b1;
            addr_rst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise)
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    // During the restart cycle the decoder still shows the
                    // result of the previous transaction, so it is ignored.
                    if (addr_done && !addr_rst_q)
                        state_d = addr_selected ? RW : IGNORE;
                    else if (scl_rise && bit_cnt_q == 4'(ADDR_BITS))
                        state_d = IGNORE;
                end
                RW: begin
                    if (scl_rise) begin
                        rw_bit_d   = SDA;
                        rw_valid_d = 1'b1;
                        bit_cnt_d  = 4'(ACK_SLOT);
                        state_d    = ACK;
                    end
                end
                ACK: begin
                    // First fall opens the ACK bit, second fall closes it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == 4'(ACK_SLOT))
                            bit_cnt_d = '0;
                        else
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(BYTE_BITS - 1))
                            byte_done_d = 1'b1;
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        addr_enable  = (state_q == ADDR);
        nack_ignored = (state_q == IGNORE);
        addr_rst     = addr_rst_q | rst;
        bit_cnt      = bit_cnt_q;
        sda_oe       = sda_oe_q;
        rw_bit       = rw_bit_q;
        rw_valid     = rw_valid_q;
        byte_done    = byte_done_q;
        bus_busy     = bus_busy_q;
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
module tb_i2c_bus_monitor;

    localparam int EV_START = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_RW    = 2;
    localparam int EV_BYTE  = 3;
    localparam int EV_IGN   = 4;
    localparam logic [6:0] I2C_ADDR = 7'h08;

    typedef struct {
        int   kind;
        logic val;
    } ev_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       ack;
        logic       en_mid;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic scl_m = 1'b1, sda_m = 1'b1, honour = 1'b1, dec_mute = 1'b0;
    logic SCL_in, SDA_in, addr_done, addr_selected;
    logic SCL, SDA, SCL_prev, scl_rise, scl_fall, start_det, stop_det;
    logic bus_busy, addr_enable, addr_rst, rw_bit, rw_valid, sda_oe;
    logic [3:0] bit_cnt;
    logic byte_done, nack_ignored;

    int checks = 0;
    int errors = 0;
    int oe_total = 0;
    int ar_total = 0;
    logic nack_q = 1'b0;
    ev_t exp_q[$];
    vec_t vecs[4];

    // Open-drain bus: the slave's pull-down wins unless the master overrides.
    assign SCL_in = scl_m;
    assign SDA_in = honour ? (sda_m & ~sda_oe) : sda_m;

    i2c_bus_monitor #(.SYNC_STAGES(2)) dut (
        .FPGA_clk     (clk),
        .rst          (rst),
        .SCL_in       (SCL_in),
        .SDA_in       (SDA_in),
        .addr_done    (addr_done),
        .addr_selected(addr_selected),
        .SCL          (SCL),
        .SDA          (SDA),
        .SCL_prev     (SCL_prev),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy),
        .addr_enable  (addr_enable),
        .addr_rst     (addr_rst),
        .rw_bit       (rw_bit),
        .rw_valid     (rw_valid),
        .sda_oe       (sda_oe),
        .bit_cnt      (bit_cnt),
        .byte_done    (byte_done),
        .nack_ignored (nack_ignored)
    );

    // Behavioural address decoder (own address 7'h08, MSB first).
    logic dec_done = 1'b0, dec_sel = 1'b0;
    logic [2:0] dec_cnt = 3'd0;
    always @(posedge clk) begin
        if (addr_rst) begin
            dec_done <= 1'b0;
            dec_sel  <= 1'b0;
            dec_cnt  <= 3'd0;
        end else if (addr_enable && !dec_done && SCL && !SCL_prev) begin
            if (SDA != I2C_ADDR[3'd6 - dec_cnt]) begin
                dec_done <= 1'b1;
                dec_sel  <= 1'b0;
            end else if (dec_cnt == 3'd6) begin
                dec_done <= 1'b1;
                dec_sel  <= 1'b1;
            end else begin
                dec_cnt <= dec_cnt + 3'd1;
            end
        end
    end
    assign addr_done     = dec_done & ~dec_mute;
    assign addr_selected = dec_sel;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic val, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_%s: got unexpected event kind %0d, expected no event", name, kind);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL sb_%s: got kind %0d val %0b, expected kind %0d val %0b",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Event monitor: every DUT strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (start_det) sb_pop(EV_START, 1'b0, "start");
            if (stop_det) sb_pop(EV_STOP, 1'b0, "stop");
            if (rw_valid) sb_pop(EV_RW, rw_bit, "rw");
            if (byte_done) sb_pop(EV_BYTE, 1'b0, "byte");
            if (nack_ignored && !nack_q) sb_pop(EV_IGN, 1'b0, "ignore");
            if (sda_oe) oe_total <= oe_total + 1;
            if (addr_rst) ar_total <= ar_total + 1;
        end
        nack_q <= nack_ignored;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic send_bit_glitch(input logic b);
        sda_m = ~b; tick(1);
        sda_m = b;  tick(1);
        sda_m = ~b; tick(1);
        sda_m = b;  tick(2);
        scl_m = 1'b1;
        tick(10);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic do_start();
        sda_m = 1'b0;
        tick(10);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic do_rstart();
        sda_m = 1'b1;
        tick(5);
        scl_m = 1'b1;
        tick(5);
        sda_m = 1'b0;
        tick(10);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        tick(5);
        scl_m = 1'b1;
        tick(5);
        sda_m = 1'b1;
        tick(10);
    endtask

    task automatic send_addr(input logic [6:0] a);
        for (int i = 0; i < 7; i++) send_bit(a[6-i]);
    endtask

    task automatic run_txn(input vec_t v);
        int oe0;
        oe0 = oe_total;
        push(EV_START, 1'b0);
        if (v.ack) begin
            push(EV_RW, v.rw);
            push(EV_BYTE, 1'b0);
        end else begin
            push(EV_IGN, 1'b0);
        end
        push(EV_STOP, 1'b0);

        do_start();
        check("busy_after_start", int'(bus_busy), 1);
        check("en_after_start", int'(addr_enable), 1);
        for (int i = 0; i < 7; i++) begin
            send_bit(v.addr[6-i]);
            if (i == 5) check("en_mid_addr", int'(addr_enable), int'(v.en_mid));
        end
        check("en_after_addr", int'(addr_enable), 0);
        send_bit(v.rw);
        if (v.ack) check("rw_bit", int'(rw_bit), int'(v.rw));
        send_bit(1'b1);
        check("ack_oe_cycles", oe_total - oe0, v.ack ? 20 : 0);
        check("nack_level", int'(nack_ignored), int'(!v.ack));
        for (int i = 0; i < 8; i++) send_bit(v.data[7-i]);
        send_bit(1'b1);
        if (v.ack) check("bitcnt_wrap", int'(bit_cnt), 0);
        do_stop();
        check("busy_after_stop", int'(bus_busy), 0);
        check("nack_after_stop", int'(nack_ignored), 0);
        check("oe_after_stop", int'(sda_oe), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int oe0, ar0;
        bit seen;

        vecs[0] = '{7'h08, 1'b0, 8'h5A, 1'b1, 1'b1};
        vecs[1] = '{7'h07, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{7'h09, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{7'h08, 1'b1, 8'h81, 1'b1, 1'b1};

        // Reset state.
        rst = 1'b1;
        tick(2);
        check("rst_SCL", int'(SCL), 1);
        check("rst_SDA", int'(SDA), 1);
        check("rst_SCL_prev", int'(SCL_prev), 1);
        check("rst_strobes", int'({scl_rise, scl_fall, start_det, stop_det, rw_valid, byte_done}), 0);
        check("rst_bus_busy", int'(bus_busy), 0);
        check("rst_addr_enable", int'(addr_enable), 0);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_rw_bit", int'(rw_bit), 0);
        check("rst_nack", int'(nack_ignored), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        check("rst_addr_rst", int'(addr_rst), 1);
        rst = 1'b0;
        tick(5);

        // Table of complete transactions.
        for (int t = 0; t < 4; t++) run_txn(vecs[t]);

        // No decoder answer: the 8th address rise must abandon the frame.
        dec_mute = 1'b1;
        oe0 = oe_total;
        push(EV_START, 1'b0);
        push(EV_IGN, 1'b0);
        push(EV_STOP, 1'b0);
        do_start();
        send_addr(7'h08);
        send_bit(1'b0);
        check("mute_nack", int'(nack_ignored), 1);
        send_bit(1'b1);
        check("mute_oe_cycles", oe_total - oe0, 0);
        do_stop();
        dec_mute = 1'b0;

        // Read of 8'hA5, repeated START, then a write.
        push(EV_START, 1'b0);
        push(EV_RW, 1'b1);
        push(EV_BYTE, 1'b0);
        push(EV_START, 1'b0);
        push(EV_RW, 1'b0);
        push(EV_BYTE, 1'b0);
        push(EV_STOP, 1'b0);
        do_start();
        send_addr(7'h08);
        send_bit(1'b1);
        check("rd_rw_bit", int'(rw_bit), 1);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> (7 - i)) & 8'h01) != 0);
        send_bit(1'b1);
        ar0 = ar_total;
        do_rstart();
        check("rs_busy", int'(bus_busy), 1);
        check("rs_addr_rst_cycles", ar_total - ar0, 1);
        check("rs_addr_enable", int'(addr_enable), 1);
        send_addr(7'h08);
        send_bit(1'b0);
        check("rs_rw_bit", int'(rw_bit), 0);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(((8'h0F >> (7 - i)) & 8'h01) != 0);
        send_bit(1'b1);
        do_stop();

        // SDA glitches while SCL is low, then SCL and SDA rising together.
        push(EV_START, 1'b0);
        push(EV_RW, 1'b0);
        push(EV_BYTE, 1'b0);
        push(EV_STOP, 1'b0);
        do_start();
        send_addr(7'h08);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit_glitch(((8'h6C >> (7 - i)) & 8'h01) != 0);
        send_bit(1'b1);
        sda_m = 1'b0;
        tick(5);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(10);
        check("simul_edge_busy", int'(bus_busy), 1);
        scl_m = 1'b0;
        tick(5);
        do_stop();

        // STOP forced by the master while the ACK is being driven.
        push(EV_START, 1'b0);
        push(EV_RW, 1'b0);
        push(EV_STOP, 1'b0);
        do_start();
        send_addr(7'h08);
        send_bit(1'b0);
        check("ack_oe_on", int'(sda_oe), 1);
        honour = 1'b0;
        sda_m = 1'b0;
        tick(5);
        scl_m = 1'b1;
        tick(5);
        sda_m = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick(1);
            seen = stop_det;
        end
        check("ack_stop_seen", int'(seen), 1);
        check("ack_oe_at_stop", int'(sda_oe), 1);
        tick(1);
        check("ack_oe_after_stop", int'(sda_oe), 0);
        check("ack_busy_after_stop", int'(bus_busy), 0);
        honour = 1'b1;
        tick(5);

        // Reset in the middle of a data byte.
        push(EV_START, 1'b0);
        push(EV_RW, 1'b0);
        do_start();
        send_addr(7'h08);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(((8'h3C >> (7 - i)) & 8'h01) != 0);
        check("data_bit_cnt5", int'(bit_cnt), 5);
        rst = 1'b1;
        tick(1);
        check("midrst_bit_cnt", int'(bit_cnt), 0);
        check("midrst_busy", int'(bus_busy), 0);
        check("midrst_oe", int'(sda_oe), 0);
        check("midrst_enable", int'(addr_enable), 0);
        check("midrst_nack", int'(nack_ignored), 0);
        rst = 1'b0;
        tick(4);
        scl_m = 1'b1;
        tick(10);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
